imem_prog: RTL and testbench
============================

Name: imem_prog

Overview:
- Parametrised, loadable, synchronous instruction memory for the multicycle CPU. Replaces the hard-coded combinational PC→instruction lookup.
- A load port lets the bench or a boot loader write program words at run time.
- The fetch port uses a request/valid handshake with configurable read latency, so the CPU fetch state can stall on slow memory.
- Unwritten words and out-of-range fetches return NOP (32'h0).

Parameters:
- ADDR_W, 16: width of fetch/load word addresses (PC width).
- DATA_W, 32: instruction word width.
- DEPTH, 64: number of words; legal addresses 0..DEPTH-1; DEPTH ≤ 2^ADDR_W.
- LATENCY, 1: fetch latency in cycles, legal 1..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- fetch_req  in  1  fetch request; accepted when high and fetch_busy low.
- fetch_addr  in  ADDR_W  word address (PC), sampled on acceptance.
- fetch_busy  out  1  fetch in flight; requests are ignored while high.
- fetch_valid  out  1  one-cycle pulse; instruction is valid.
- instruction  out  DATA_W  fetched word; holds its value until the next fetch_valid.
- fetch_fault  out  1  pulses with fetch_valid when the fetched address is ≥ DEPTH.
- load_en  in  1  write strobe.
- load_addr  in  ADDR_W  write word address.
- load_data  in  DATA_W  write data.
- load_err  out  1  one-cycle pulse, the cycle after a load to address ≥ DEPTH.

Behaviour:
- Reset values (async on rst_n low): fetch_busy=0, fetch_valid=0, fetch_fault=0, load_err=0, instruction=0. All per-word written flags are cleared, FSM goes to IDLE, latency counter is 0. The memory array itself is not reset.
- Read rule: a word whose written flag is clear reads as 0 (NOP), whatever the array holds.
- Load: at an edge with load_en=1 and load_addr<DEPTH, the word is written and its flag set. Out-of-range loads change nothing and pulse load_err.
- FSM has two states, IDLE and WAIT.
  - IDLE: an edge with fetch_req=1 is the accept edge k. The read result (data, or 0 plus fault if out of range) is captured into an internal holding register at edge k.
    - LATENCY=1: at edge k, instruction and fault are loaded, fetch_valid is set, and the FSM stays in IDLE.
    - LATENCY>1: the counter is loaded with LATENCY-1 and the FSM goes to WAIT; fetch_busy=1.
  - WAIT: the counter decrements each edge. On the edge where it reaches 0, instruction, fetch_valid and fetch_fault are driven from the holding register and the FSM returns to IDLE.
- Timing: fetch_valid is high exactly in the cycle after edge k+LATENCY-1, i.e. LATENCY edges after the request was presented. fetch_busy is high in the cycles after edges k..k+LATENCY-2 and is never high for LATENCY=1.
- Throughput: one fetch per LATENCY cycles. A new request may be presented in the fetch_valid cycle; back-to-back fetches are allowed.
- Requests while busy are dropped, not queued. The requester must hold fetch_req until it sees !fetch_busy.
- Load and fetch on the same edge to the same address: the fetch returns the old value (read-before-write), including the old written flag.
- Loads are accepted in any FSM state. A load to an address already in flight does not alter the held result.
- rst_n low mid-fetch aborts the fetch; no fetch_valid is produced for it.
- Address compare is unsigned on full ADDR_W. Words are not aliased and addresses do not wrap.

Optional Feature:
- Macro IMEM_BOOT_PROG_EN.
- Defined: words 0..2 whose written flag is clear read a built-in boot program instead of 0: word 0=32'hE4210007 (LI R1,7), word 1=32'h48210000 (ADD), word 2=32'hC8220F0F (ADDI R2,R1,0x0F0F). A load to these addresses overrides the boot word until the next reset.
- Undefined: unwritten words read 0. No boot logic is synthesised.

Test Plan:
- LATENCY=1: load addr 5 = 32'hDEADBEEF, then fetch addr 5 → fetch_valid the cycle after the accept edge, instruction=DEADBEEF, fault=0, busy never high. Fetch addr 6 (unwritten) → 0.
- LATENCY=3: fetch at edge k → busy high for 2 cycles, valid at cycle after edge k+2. Request during busy is ignored; a request held high through the valid cycle is accepted there.
- Fetch addr 64 with DEPTH=64 → instruction=0, fetch_fault=1 with valid. Load addr 70 → load_err pulse, memory unchanged.
- Same-edge load addr 3=32'h11111111 and fetch addr 3 (previously 32'h22222222) → returns 22222222; a second fetch returns 11111111.
- Assert rst_n low during a LATENCY=4 fetch → all outputs 0 immediately, no valid. A later fetch of a previously loaded address returns 0 (flags cleared).
- IMEM_BOOT_PROG_EN defined: fetch 0,1,2 after reset → E4210007, 48210000, C8220F0F. Load addr 1=0 then fetch 1 → 0. Macro undefined: fetch 0 → 0.

Source files
------------

// File: rtl/imem_prog.sv
// Loadable synchronous instruction memory with a req/valid fetch port and configurable read latency.
// Optional built-in boot program for words 0..2 is enabled by defining IMEM_BOOT_PROG_EN.
module imem_prog #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_busy,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] instruction,
   output logic              fetch_fault,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_err
);

   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned CMP_W  = ADDR_W + 1;
   localparam bit          SINGLE = (LATENCY == 1);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_written;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_fault;
   logic [DATA_W-1:0] r_instr;
   logic              r_valid;
   logic              r_fault;
   logic              r_busy;
   logic              r_load_err;

   state_t            w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [DATA_W-1:0] w_hold_nxt;
   logic              w_hold_fault_nxt;
   logic [DATA_W-1:0] w_instr_nxt;
   logic              w_valid_nxt;
   logic              w_fault_nxt;
   logic              w_busy_nxt;

   logic              w_fetch_in_range;
   logic [IDX_W-1:0]  w_fetch_idx;
   logic              w_load_in_range;
   logic [IDX_W-1:0]  w_load_idx;
   logic [DATA_W-1:0] w_unwritten;
   logic [DATA_W-1:0] w_rd_data;

   // Unsigned compare one bit wider so DEPTH == 2^ADDR_W is representable.
   assign w_fetch_in_range = ({1'b0, fetch_addr} < CMP_W'(DEPTH));
   assign w_load_in_range  = ({1'b0, load_addr}  < CMP_W'(DEPTH));
   assign w_fetch_idx      = fetch_addr[IDX_W-1:0];
   assign w_load_idx       = load_addr[IDX_W-1:0];

`ifdef IMEM_BOOT_PROG_EN
   function automatic logic [DATA_W-1:0] boot_word(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] w;
      w = '0;
      case (a)
         ADDR_W'(0): w = DATA_W'(32'hE4210007);
         ADDR_W'(1): w = DATA_W'(32'h48210000);
         ADDR_W'(2): w = DATA_W'(32'hC8220F0F);
         default:    w = '0;
      endcase
      return w;
   endfunction

   assign w_unwritten = boot_word(fetch_addr);
`else
   assign w_unwritten = '0;
`endif

   // Unwritten words never expose stale array contents.
   always_comb begin
      w_rd_data = '0;
      if (w_fetch_in_range) begin
         if (r_written[w_fetch_idx]) begin
            w_rd_data = r_mem[w_fetch_idx];
         end else begin
            w_rd_data = w_unwritten;
         end
      end
   end

   // Storage array is intentionally not reset; the written flags gate reads.
   always_ff @(posedge clk) begin
      if (load_en && w_load_in_range) begin
         r_mem[w_load_idx] <= load_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_written  <= '0;
         r_load_err <= 1'b0;
      end else begin
         r_load_err <= load_en && !w_load_in_range;
         if (load_en && w_load_in_range) begin
            r_written[w_load_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_hold       <= '0;
         r_hold_fault <= 1'b0;
         r_instr      <= '0;
         r_valid      <= 1'b0;
         r_fault      <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_hold       <= w_hold_nxt;
         r_hold_fault <= w_hold_fault_nxt;
         r_instr      <= w_instr_nxt;
         r_valid      <= w_valid_nxt;
         r_fault      <= w_fault_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   // Next-state and output logic; valid/fault are single-cycle pulses.
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_hold_nxt       = r_hold;
      w_hold_fault_nxt = r_hold_fault;
      w_instr_nxt      = r_instr;
      w_valid_nxt      = 1'b0;
      w_fault_nxt      = 1'b0;
      w_busy_nxt       = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (fetch_req) begin
               w_hold_nxt       = w_rd_data;
               w_hold_fault_nxt = !w_fetch_in_range;
               if (SINGLE) begin
                  w_instr_nxt = w_rd_data;
                  w_valid_nxt = 1'b1;
                  w_fault_nxt = !w_fetch_in_range;
               end else begin
                  w_cnt_nxt   = CNT_W'(LATENCY - 1);
                  w_state_nxt = S_WAIT;
                  w_busy_nxt  = 1'b1;
               end
            end
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_instr_nxt = r_hold;
               w_valid_nxt = 1'b1;
               w_fault_nxt = r_hold_fault;
               w_state_nxt = S_IDLE;
            end else begin
               w_busy_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign fetch_busy  = r_busy;
   assign fetch_valid = r_valid;
   assign fetch_fault = r_fault;
   assign instruction = r_instr;
   assign load_err    = r_load_err;

endmodule

// File: tb/tb_imem_prog.sv
// Directed bench for imem_prog: three instances at LATENCY 1, 3 and 4 share the load port and reset.
// Boot-word expectations follow IMEM_BOOT_PROG_EN when it is defined for the build.
module tb_imem_prog;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_en;
   logic [15:0] load_addr;
   logic [31:0] load_data;

   logic        req   [3];
   logic [15:0] faddr [3];
   logic        busy  [3];
   logic        valid [3];
   logic        fault [3];
   logic        lerr  [3];
   logic [31:0] instr [3];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   imem_prog #(.ADDR_W(16), .DATA_W(32), .DEPTH(64), .LATENCY(1)) u_l1 (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(req[0]), .fetch_addr(faddr[0]), .fetch_busy(busy[0]),
      .fetch_valid(valid[0]), .instruction(instr[0]), .fetch_fault(fault[0]),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_err(lerr[0])
   );

   imem_prog #(.ADDR_W(16), .DATA_W(32), .DEPTH(64), .LATENCY(3)) u_l3 (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(req[1]), .fetch_addr(faddr[1]), .fetch_busy(busy[1]),
      .fetch_valid(valid[1]), .instruction(instr[1]), .fetch_fault(fault[1]),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_err(lerr[1])
   );

   imem_prog #(.ADDR_W(16), .DATA_W(32), .DEPTH(64), .LATENCY(4)) u_l4 (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(req[2]), .fetch_addr(faddr[2]), .fetch_busy(busy[2]),
      .fetch_valid(valid[2]), .instruction(instr[2]), .fetch_fault(fault[2]),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_err(lerr[2])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input int d, input logic b, input logic v,
                            input logic f, input logic [31:0] ins);
      check({tag, ".busy"},  32'(busy[d]),  32'(b));
      check({tag, ".valid"}, 32'(valid[d]), 32'(v));
      check({tag, ".fault"}, 32'(fault[d]), 32'(f));
      check({tag, ".instr"}, instr[d], ins);
   endtask

   task automatic load(input logic [15:0] a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic fetch1(input logic [15:0] a);
      req[0]   = 1'b1;
      faddr[0] = a;
      tick();
      req[0]   = 1'b0;
   endtask

   logic [31:0] boot0, boot1, boot2;

   initial begin
`ifdef IMEM_BOOT_PROG_EN
      boot0 = 32'hE4210007;
      boot1 = 32'h48210000;
      boot2 = 32'hC8220F0F;
`else
      boot0 = 32'h0;
      boot1 = 32'h0;
      boot2 = 32'h0;
`endif
      rst_n     = 1'b0;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      for (int i = 0; i < 3; i++) begin
         req[i]   = 1'b0;
         faddr[i] = '0;
      end
      #12;
      for (int i = 0; i < 3; i++) begin
         check_out($sformatf("reset_d%0d", i), i, 1'b0, 1'b0, 1'b0, 32'h0);
         check($sformatf("reset_lerr_d%0d", i), 32'(lerr[i]), 32'h0);
      end
      rst_n = 1'b1;
      tick();

      // Latency 1: basic load/fetch, out-of-range fetch, unwritten word
      load(16'd5, 32'hDEADBEEF);
      check("load5_lerr", 32'(lerr[0]), 32'h0);
      fetch1(16'd5);
      check_out("l1_fetch5", 0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
      tick();
      check_out("l1_hold", 0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
      fetch1(16'd64);
      check_out("l1_fetch64", 0, 1'b0, 1'b1, 1'b1, 32'h0);
      load(16'd70, 32'h12345678);
      check("load70_lerr", 32'(lerr[0]), 32'h1);
      tick();
      check("load70_lerr_pulse", 32'(lerr[0]), 32'h0);
      fetch1(16'd6);
      check_out("l1_fetch6_noalias", 0, 1'b0, 1'b1, 1'b0, 32'h0);

      // Latency 3: held request ignored while busy, re-accepted in the valid cycle
      req[1]   = 1'b1;
      faddr[1] = 16'd5;
      tick();
      check_out("l3_k", 1, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      check_out("l3_k1", 1, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      check_out("l3_k2", 1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
      faddr[1] = 16'd6;
      tick();
      check_out("l3_reaccept", 1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
      req[1] = 1'b0;
      tick();
      check_out("l3_reacc_k1", 1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
      tick();
      check_out("l3_reacc_k2", 1, 1'b0, 1'b1, 1'b0, 32'h0);
      tick();
      check_out("l3_idle", 1, 1'b0, 1'b0, 1'b0, 32'h0);

      // Same-edge load and fetch returns the old word and old flag
      load(16'd3, 32'h22222222);
      load_en   = 1'b1;
      load_addr = 16'd3;
      load_data = 32'h11111111;
      fetch1(16'd3);
      load_en = 1'b0;
      check_out("rbw_old", 0, 1'b0, 1'b1, 1'b0, 32'h22222222);
      fetch1(16'd3);
      check_out("rbw_new", 0, 1'b0, 1'b1, 1'b0, 32'h11111111);
      load_en   = 1'b1;
      load_addr = 16'd7;
      load_data = 32'hAAAA5555;
      fetch1(16'd7);
      load_en = 1'b0;
      check_out("rbw_flag", 0, 1'b0, 1'b1, 1'b0, 32'h0);

      // Latency 4: load during WAIT does not disturb the held result
      req[2]   = 1'b1;
      faddr[2] = 16'd3;
      tick();
      req[2] = 1'b0;
      check_out("l4_k", 2, 1'b1, 1'b0, 1'b0, 32'h0);
      load(16'd3, 32'h33333333);
      tick();
      check_out("l4_k2", 2, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      check_out("l4_k3", 2, 1'b0, 1'b1, 1'b0, 32'h11111111);

      // Reset in the middle of a latency-4 fetch
      req[2]   = 1'b1;
      faddr[2] = 16'd5;
      tick();
      req[2] = 1'b0;
      tick();
      check("l4_midbusy", 32'(busy[2]), 32'h1);
      rst_n = 1'b0;
      #1;
      check_out("l4_abort", 2, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("l4_novalid_%0d", i), 32'(valid[2]), 32'h0);
      end

      fetch1(16'd5);
      check_out("flags_cleared", 0, 1'b0, 1'b1, 1'b0, 32'h0);
      fetch1(16'd0);
      check_out("boot0", 0, 1'b0, 1'b1, 1'b0, boot0);
      fetch1(16'd1);
      check_out("boot1", 0, 1'b0, 1'b1, 1'b0, boot1);
      fetch1(16'd2);
      check_out("boot2", 0, 1'b0, 1'b1, 1'b0, boot2);
      load(16'd1, 32'h0);
      fetch1(16'd1);
      check_out("boot1_override", 0, 1'b0, 1'b1, 1'b0, 32'h0);
      fetch1(16'd2);
      check_out("boot2_kept", 0, 1'b0, 1'b1, 1'b0, boot2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
